// File: rtl/or1200_qmem_sram_resp.sv
// QMEM responder: completes one outstanding load/store/fetch against an internal
// word-addressed SRAM after a fixed number of wait states, with ack or error pulse.
module or1200_qmem_sram_resp #(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned AW          = 8,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          qmem_en_i,
    input  logic          qmem_we_i,
    input  logic [3:0]    qmem_sel_i,
    input  logic [AW-1:0] qmem_addr_i,
    input  logic [31:0]   qmem_dat_i,
    output logic [31:0]   qmem_dat_o,
    output logic          qmem_ack_o,
    output logic          qmem_err_o
);

    localparam int unsigned CW = 4;
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [31:0]     mem [DEPTH];

    logic            finish_c;
    logic            in_range_c;
    logic            wr_c;
    logic [IW-1:0]   idx_c;

    // The edge that enters DONE is the one that performs the access.
    always_comb begin
        finish_c = 1'b0;
        case (state)
            ST_IDLE: finish_c = qmem_en_i && (WAIT_STATES == 0);
            ST_WAIT: finish_c = qmem_en_i && (cnt == CW'(0));
            default: finish_c = 1'b0;
        endcase
        in_range_c = 32'(qmem_addr_i) < DEPTH;
        idx_c      = IW'(qmem_addr_i);
        wr_c       = finish_c && in_range_c && qmem_we_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            qmem_ack_o <= 1'b0;
            qmem_err_o <= 1'b0;
            qmem_dat_o <= '0;
        end else begin
            qmem_ack_o <= 1'b0;
            qmem_err_o <= 1'b0;
            if (finish_c) begin
                state      <= ST_DONE;
                qmem_ack_o <= in_range_c;
                qmem_err_o <= !in_range_c;
                if (in_range_c && !qmem_we_i) begin
                    qmem_dat_o <= mem[idx_c];
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (qmem_en_i) begin
                            state <= ST_WAIT;
                            cnt   <= CW'(WAIT_STATES - 1);
                        end
                    end
                    // Dropping en mid-wait abandons the request silently.
                    ST_WAIT: begin
                        if (!qmem_en_i) begin
                            state <= ST_IDLE;
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // Array is not reset; a write is suppressed on any edge where reset is held.
    always_ff @(posedge clk) begin
        if (wr_c && rst_n) begin
            for (int n = 0; n < 4; n++) begin
                if (qmem_sel_i[n]) begin
                    mem[idx_c][8*n +: 8] <= qmem_dat_i[8*n +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_or1200_qmem_sram_resp.sv
// Scoreboard bench for or1200_qmem_sram_resp: three instances with 1, 3 and 0
// wait states share request buses; each has its own en and outputs.
module tb_or1200_qmem_sram_resp;

    localparam int unsigned AW = 9;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  en;
    logic [2:0]  ack;
    logic [2:0]  err;
    logic        we;
    logic [3:0]  sel;
    logic [AW-1:0] addr;
    logic [31:0] wdat;
    logic [31:0] rdat [3];

    always #5 clk = ~clk;

    or1200_qmem_sram_resp #(.DEPTH(256), .AW(AW), .WAIT_STATES(1)) u_ws1 (
        .clk(clk), .rst_n(rst_n), .qmem_en_i(en[0]), .qmem_we_i(we),
        .qmem_sel_i(sel), .qmem_addr_i(addr), .qmem_dat_i(wdat),
        .qmem_dat_o(rdat[0]), .qmem_ack_o(ack[0]), .qmem_err_o(err[0]));

    or1200_qmem_sram_resp #(.DEPTH(256), .AW(AW), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .rst_n(rst_n), .qmem_en_i(en[1]), .qmem_we_i(we),
        .qmem_sel_i(sel), .qmem_addr_i(addr), .qmem_dat_i(wdat),
        .qmem_dat_o(rdat[1]), .qmem_ack_o(ack[1]), .qmem_err_o(err[1]));

    or1200_qmem_sram_resp #(.DEPTH(256), .AW(AW), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst_n(rst_n), .qmem_en_i(en[2]), .qmem_we_i(we),
        .qmem_sel_i(sel), .qmem_addr_i(addr), .qmem_dat_i(wdat),
        .qmem_dat_o(rdat[2]), .qmem_ack_o(ack[2]), .qmem_err_o(err[2]));

    typedef struct {
        int          d;
        bit          e;
        logic [31:0] dat;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    exp_t        mx;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    logic [31:0] last [3];

    function automatic int ws_of(input int d);
        case (d)
            0:       return 1;
            1:       return 3;
            default: return 0;
        endcase
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every ack/err pulse must match the oldest expected response.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 3; d++) begin
                if (ack[d] || err[d]) begin
                    total++;
                    if (ack[d] && err[d]) begin
                        bad++;
                        $display("FAIL both_pulses dut%0d: ack=1 err=1, required only one", d);
                    end else if (q.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_pulse dut%0d cyc=%0d: ack=%b err=%b, required none",
                                 d, cyc, ack[d], err[d]);
                    end else begin
                        mx = q.pop_front();
                        if (mx.d != d || mx.e != err[d] || rdat[d] !== mx.dat || cyc != mx.cyc) begin
                            bad++;
                            $display("FAIL response dut%0d: err=%b dat=%h cyc=%0d, required dut%0d err=%b dat=%h cyc=%0d",
                                     d, err[d], rdat[d], cyc, mx.d, mx.e, mx.dat, mx.cyc);
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    function automatic void push(input int d, input bit w, input bit e,
                                 input logic [31:0] ld, input int at);
        exp_t x;
        x.d   = d;
        x.e   = e;
        x.dat = (w || e) ? last[d] : ld;
        x.cyc = at;
        last[d] = x.dat;
        q.push_back(x);
    endfunction

    // One request: drive, push expectation, hold en until the pulse is seen.
    task automatic req(input int d, input bit w, input logic [3:0] s, input logic [AW-1:0] a,
                       input logic [31:0] wd, input bit e, input logic [31:0] ld);
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        we = w; sel = s; addr = a; wdat = wd; en[d] = 1'b1;
        push(d, w, e, ld, cyc + 1 + ws_of(d));
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ack[d] || err[d]) begin
                seen = 1'b1;
                break;
            end
        end
        en[d] = 1'b0;
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL timeout dut%0d addr=%0d: no ack/err, required one", d, a);
            if (q.size() != 0) void'(q.pop_back());
        end
    endtask

    logic [31:0] bb [3];

    initial begin
        bb[0] = 32'h1111_0000;
        bb[1] = 32'h2222_0001;
        bb[2] = 32'h3333_0002;
        for (int d = 0; d < 3; d++) last[d] = 32'h0;
        rst_n = 1'b0;
        en = '0; we = 1'b0; sel = '0; addr = '0; wdat = '0;

        // Reset with random activity on inputs.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            en = 3'($urandom); we = 1'($urandom); sel = 4'($urandom);
            addr = AW'($urandom); wdat = $urandom;
        end
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_ack%0d", d), 32'(ack[d]), 32'h0);
            chk($sformatf("rst_err%0d", d), 32'(err[d]), 32'h0);
            chk($sformatf("rst_dat%0d", d), rdat[d], 32'h0);
        end
        en = '0;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // One wait state: full, byte and empty stores, loads, out-of-range.
        req(0, 1'b1, 4'hF, 9'd5, 32'hDEAD_BEEF, 1'b0, 32'h0);
        req(0, 1'b0, 4'hF, 9'd5, 32'h0, 1'b0, 32'hDEAD_BEEF);
        req(0, 1'b1, 4'b0010, 9'd5, 32'h0000_AA00, 1'b0, 32'h0);
        req(0, 1'b0, 4'hF, 9'd5, 32'h0, 1'b0, 32'hDEAD_AAEF);
        req(0, 1'b1, 4'h0, 9'd5, 32'h1234_5678, 1'b0, 32'h0);
        req(0, 1'b0, 4'b0001, 9'd5, 32'h0, 1'b0, 32'hDEAD_AAEF);
        req(0, 1'b0, 4'hF, 9'd300, 32'h0, 1'b1, 32'h0);
        req(0, 1'b1, 4'hF, 9'd300, 32'hFFFF_FFFF, 1'b1, 32'h0);
        req(0, 1'b0, 4'hF, 9'd5, 32'h0, 1'b0, 32'hDEAD_AAEF);

        // Three wait states: abort by dropping en mid-wait.
        req(1, 1'b1, 4'hF, 9'd7, 32'h1111_2222, 1'b0, 32'h0);
        @(negedge clk);
        we = 1'b1; sel = 4'hF; addr = 9'd7; wdat = 32'h9999_9999; en[1] = 1'b1;
        repeat (2) @(negedge clk);
        en[1] = 1'b0;
        repeat (6) @(negedge clk);
        req(1, 1'b0, 4'hF, 9'd7, 32'h0, 1'b0, 32'h1111_2222);

        // Reset pulse mid-wait drops the store.
        @(negedge clk);
        we = 1'b1; sel = 4'hF; addr = 9'd7; wdat = 32'h7777_7777; en[1] = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        en[1] = 1'b0;
        #1;
        chk("midrst_ack", 32'(ack[1]), 32'h0);
        chk("midrst_dat", rdat[1], 32'h0);
        for (int d = 0; d < 3; d++) last[d] = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        req(1, 1'b0, 4'hF, 9'd7, 32'h0, 1'b0, 32'h1111_2222);

        // Zero wait states: back-to-back with en held continuously.
        @(negedge clk);
        en[2] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            we = 1'b1; sel = 4'hF; addr = AW'(k); wdat = bb[k];
            push(2, 1'b1, 1'b0, 32'h0, cyc + 1);
            repeat (2) @(negedge clk);
        end
        we = 1'b0;
        addr = 9'd0;
        push(2, 1'b0, 1'b0, 32'h1111_0000, cyc + 1);
        repeat (2) @(negedge clk);
        addr = 9'd1;
        push(2, 1'b0, 1'b0, 32'h2222_0001, cyc + 1);
        repeat (2) @(negedge clk);
        addr = 9'd2;
        push(2, 1'b0, 1'b0, 32'h3333_0002, cyc + 1);
        repeat (2) @(negedge clk);
        en[2] = 1'b0;

        repeat (5) @(negedge clk);
        chk("pending_responses", 32'(q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
